// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory-port arbiter: FSM states, owner ids, widths.
// Pure constants, no latency or flow control of its own.
package mem_arbiter_pkg;

    localparam int WORD_W   = 32;
    localparam int CNT_W    = 3;
    localparam int STARVE_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant pick: MEM wins ties unless IF has waited STARVE_LIMIT MEM grants.
// Zero latency; requesters not picked simply keep their req held.
module mem_arb_grant
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                if_req,
    input  logic                mem_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                grant_valid,
    output logic                grant_owner
);

    logic w_if_forced;

    assign w_if_forced = if_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign grant_valid = if_req | mem_req;
    assign grant_owner = (mem_req && !w_if_forced) ? OWN_MEM : OWN_IF;

endmodule

// File: rtl/mem_arbiter.sv
// Registered IF/MEM arbiter for the shared MMU port: req at cycle 0, strobes 1..N, ack at N+1.
// Backpressure is the missing ack: a requester holds req (and its stage) until its one-cycle ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_ack,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_bytemode,
    input  logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mmu_read,
    output logic              mmu_write,
    output logic              mmu_bytemode,
    output logic [WORD_W-1:0] mmu_addr,
    output logic [WORD_W-1:0] mmu_wdata,
    input  logic [WORD_W-1:0] mmu_rdata
);

    localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    logic [1:0]          r_state;
    logic                r_owner;
    logic                r_we;
    logic [CNT_W-1:0]    r_cnt;
    logic [STARVE_W-1:0] r_starve_cnt;

    logic w_grant_valid;
    logic w_grant_owner;

    mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .if_req      (if_req),
        .mem_req     (mem_req),
        .starve_cnt  (r_starve_cnt),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_starve_cnt <= '0;
            if_ack       <= 1'b0;
            mem_ack      <= 1'b0;
            if_rdata     <= '0;
            mem_rdata    <= '0;
            mmu_read     <= 1'b0;
            mmu_write    <= 1'b0;
            mmu_bytemode <= 1'b0;
            mmu_addr     <= '0;
            mmu_wdata    <= '0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= CNT_INIT;
                        r_owner <= w_grant_owner;
                        if (w_grant_owner == OWN_MEM) begin
                            r_we         <= mem_we;
                            mmu_read     <= !mem_we;
                            mmu_write    <= mem_we;
                            mmu_bytemode <= mem_bytemode;
                            mmu_addr     <= mem_addr;
                            mmu_wdata    <= mem_wdata;
                            // Only grants that make IF wait count toward forcing IF in.
                            if (if_req && (r_starve_cnt != STARVE_MAX)) begin
                                r_starve_cnt <= r_starve_cnt + 1'b1;
                            end
                        end else begin
                            r_we         <= 1'b0;
                            mmu_read     <= 1'b1;
                            mmu_write    <= 1'b0;
                            mmu_bytemode <= 1'b0;
                            mmu_addr     <= if_addr;
                            mmu_wdata    <= '0;
                            r_starve_cnt <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state   <= ST_DONE;
                        mmu_read  <= 1'b0;
                        mmu_write <= 1'b0;
                        if (r_owner == OWN_MEM) begin
                            mem_ack <= 1'b1;
                            if (!r_we) begin
                                mem_rdata <= mmu_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mmu_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    mmu_read  <= 1'b0;
                    mmu_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level schedule model (grant at g, strobes g+1..g+N, ack g+N+1).
module tb_mem_arbiter;

    localparam int N   = 2;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic        mem_bytemode = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mmu_read;
    logic        mmu_write;
    logic        mmu_bytemode;
    logic [31:0] mmu_addr;
    logic [31:0] mmu_wdata;
    logic [31:0] mmu_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ACCESS_CYCLES (N),
        .STARVE_LIMIT  (LIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .if_rdata     (if_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_bytemode (mem_bytemode),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .mmu_read     (mmu_read),
        .mmu_write    (mmu_write),
        .mmu_bytemode (mmu_bytemode),
        .mmu_addr     (mmu_addr),
        .mmu_wdata    (mmu_wdata),
        .mmu_rdata    (mmu_rdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding access described by its grant cycle.
    int          cyc;
    bit          act;
    int          g;
    int          free_at;
    int          starve;
    bit          m_own;
    bit          m_we;
    bit          m_bm;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic [31:0] m_cap;
    logic [31:0] exp_if_rd;
    logic [31:0] exp_mem_rd;

    // Observation log for directed checks.
    int ack_q[$];
    int last_if_ack;
    int last_mem_ack;
    int first_wr;
    int n_rd;
    int n_wr;
    bit if_rereq;
    bit mem_rereq;

    function automatic int ack_at(input int i);
        return (i < ack_q.size()) ? ack_q[i] : -1;
    endfunction

    task automatic new_if(input bit r);
        if_req  = r;
        if_addr = $urandom;
    endtask

    task automatic new_mem(input bit r);
        mem_req      = r;
        mem_we       = 1'($urandom_range(0, 1));
        mem_bytemode = 1'($urandom_range(0, 1));
        mem_addr     = $urandom;
        mem_wdata    = $urandom;
    endtask

    // Called at a negedge with rst low: check reset outputs, release, restart model at cycle 0.
    task automatic rst_release();
        check("rst_ctl", 32'({mmu_read, mmu_write, if_ack, mem_ack}), 32'd0);
        check("rst_addr", mmu_addr, 32'd0);
        check("rst_wdata", mmu_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        rst          = 1'b1;
        cyc          = 0;
        act          = 1'b0;
        g            = -100;
        free_at      = 0;
        starve       = 0;
        exp_if_rd    = '0;
        exp_mem_rd   = '0;
        ack_q.delete();
        last_if_ack  = -1;
        last_mem_ack = -1;
        first_wr     = -1;
        n_rd         = 0;
        n_wr         = 0;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        if_req       = 1'b0;
        if_addr      = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_bytemode = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_rereq     = 1'b0;
        mem_rereq    = 1'b0;
        repeat (2) @(negedge clk);
        rst_release();
    endtask

    // One cycle: check outputs of cycle cyc, react as requesters, advance the model.
    task automatic step(input bit auto_mode);
        bit strobe;
        bit ackc;
        bit pick_mem;
        strobe = act && (cyc >= g + 1) && (cyc <= g + N);
        ackc   = act && (cyc == g + N + 1);
        check("strobes_acks", 32'({mmu_read, mmu_write, if_ack, mem_ack}),
              32'({strobe && !m_we, strobe && m_we, ackc && !m_own, ackc && m_own}));
        if (mmu_read) n_rd++;
        if (mmu_write) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
        end
        if (strobe) begin
            check("mmu_addr", mmu_addr, m_addr);
            check("mmu_bytemode", 32'(mmu_bytemode), 32'(m_bm));
            if (m_we) check("mmu_wdata", mmu_wdata, m_wd);
        end
        if (ackc) begin
            if (m_own) begin
                if (!m_we) exp_mem_rd = m_cap;
                check("mem_rdata", mem_rdata, exp_mem_rd);
            end else begin
                exp_if_rd = m_cap;
                check("if_rdata", if_rdata, exp_if_rd);
            end
        end

        if (if_ack) begin
            last_if_ack = cyc;
            ack_q.push_back(0);
            if (auto_mode) new_if(1'($urandom_range(0, 1)));
            else if (!if_rereq) if_req = 1'b0;
        end else if (auto_mode && !if_req && ($urandom_range(0, 3) == 0)) begin
            new_if(1'b1);
        end
        if (mem_ack) begin
            last_mem_ack = cyc;
            ack_q.push_back(1);
            if (auto_mode) new_mem(1'($urandom_range(0, 1)));
            else if (!mem_rereq) mem_req = 1'b0;
        end else if (auto_mode && !mem_req && ($urandom_range(0, 2) == 0)) begin
            new_mem(1'b1);
        end
        if (auto_mode) mmu_rdata = $urandom;

        if (act && (cyc == g + N)) m_cap = mmu_rdata;
        if ((cyc >= free_at) && (if_req || mem_req)) begin
            pick_mem = mem_req && !(if_req && (starve == LIM));
            act      = 1'b1;
            g        = cyc;
            free_at  = cyc + N + 2;
            m_own    = pick_mem;
            if (pick_mem) begin
                m_we   = mem_we;
                m_bm   = mem_bytemode;
                m_addr = mem_addr;
                m_wd   = mem_wdata;
                if (if_req) starve = (starve < 15) ? starve + 1 : 15;
            end else begin
                m_we   = 1'b0;
                m_bm   = 1'b0;
                m_addr = if_addr;
                m_wd   = '0;
                starve = 0;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // Single IF read.
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h8000_0000;
        mmu_rdata = 32'h3C01_1234;
        repeat (6) step(1'b0);
        check("t1_if_ack_cyc", last_if_ack, 32'd3);
        check("t1_if_rdata", if_rdata, 32'h3C01_1234);
        check("t1_n_read", n_rd, 32'd2);
        check("t1_acks", ack_q.size(), 32'd1);

        // MEM byte write: rdata must not move.
        do_reset();
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_bytemode = 1'b1;
        mem_addr     = 32'h8040_0003;
        mem_wdata    = 32'h0000_00AB;
        repeat (6) step(1'b0);
        check("t2_mem_ack_cyc", last_mem_ack, 32'd3);
        check("t2_n_write", n_wr, 32'd2);
        check("t2_n_read", n_rd, 32'd0);
        check("t2_mem_rdata", mem_rdata, 32'd0);

        // Simultaneous requests: MEM first, IF next.
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h0000_1000;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = 32'h0000_2000;
        mmu_rdata = 32'h1111_2222;
        repeat (10) step(1'b0);
        check("t3_mem_ack_cyc", last_mem_ack, 32'd3);
        check("t3_if_ack_cyc", last_if_ack, 32'd7);
        check("t3_order", 32'(ack_at(0)), 32'd1);

        // Starvation: both always requesting.
        do_reset();
        if_rereq  = 1'b1;
        mem_rereq = 1'b1;
        if_req    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        repeat (42) step(1'b0);
        for (int i = 0; i < 10; i++) begin
            check("t4_ack_order", 32'(ack_at(i)), 32'(exp_pat[i]));
        end

        // Async reset in the middle of a MEM write.
        do_reset();
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h8000_0010;
        mem_wdata = 32'hDEAD_BEEF;
        step(1'b0);
        check("t5_write_before", 32'(mmu_write), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("t5_async_drop", 32'({mmu_read, mmu_write}), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("t5_no_ack", 32'({mmu_read, mmu_write, if_ack, mem_ack}), 32'd0);
        end
        rst_release();
        repeat (6) step(1'b0);
        check("t5_first_write", first_wr, 32'd1);
        check("t5_mem_ack_cyc", last_mem_ack, 32'd3);

        // Random traffic against the model.
        do_reset();
        repeat (3000) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
